// File: rtl/ifft_butterfly_pipe.sv
// Inverse radix-2 butterfly, two-stage valid/ready pipeline.
//   out1 = (A + B*W)/2, out2 = (A - B*W)/2, with W = 1 or +j.
// Optional feature macro: IBFLY_ROUND_EN
//   defined   -> halving rounds half up ((s+1)>>>1) and clamps to the DATA_W range
//   undefined -> halving is a plain floor shift (s>>>1); no clamp is needed
module ifft_butterfly_pipe #(
    parameter int DATA_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] y1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] y2,
    input  logic                     twiddle_j,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] xout1,
    output logic signed [DATA_W-1:0] yout1,
    output logic signed [DATA_W-1:0] xout2,
    output logic signed [DATA_W-1:0] yout2,
    output logic [COUNT_W-1:0]       pair_count
);

    // Rotated operand needs one extra bit so that -(-2^(DATA_W-1)) is exact;
    // the butterfly sums are formed with two extra bits.
    localparam int BW = DATA_W + 1;
    localparam int SW = DATA_W + 2;

`ifdef IBFLY_ROUND_EN
    localparam logic signed [SW-1:0] ONE   = 1;
    localparam logic signed [SW-1:0] MAX_V = SW'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = -MAX_V - ONE;
`endif

    // Handshake: a transfer happens on an edge where valid && ready on that side.
    // Stage 2 (the output register) advances when it is empty or the consumer
    // takes it. Stage 1 loads whenever it is empty or stage 2 advances, which is
    // exactly in_ready, so in_ready is combinational from out_ready. A stalled
    // output register holds its data unchanged.
    logic adv2;
    logic adv1;
    logic s1_valid;
    logic s2_valid;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = adv2;
    assign in_ready  = !s1_valid || adv1;
    assign out_valid = s2_valid;

    // Twiddle rotation: W^0 passes B through, +j maps (x2, y2) to (-y2, x2).
    logic signed [BW-1:0] x2_e;
    logic signed [BW-1:0] y2_e;
    logic signed [BW-1:0] y2_neg;
    logic signed [BW-1:0] bt_x;
    logic signed [BW-1:0] bt_y;

    assign x2_e   = {x2[DATA_W-1], x2};
    assign y2_e   = {y2[DATA_W-1], y2};
    assign y2_neg = -y2_e;
    assign bt_x   = twiddle_j ? y2_neg : x2_e;
    assign bt_y   = twiddle_j ? x2_e : y2_e;

    logic signed [DATA_W-1:0] s1_ax;
    logic signed [DATA_W-1:0] s1_ay;
    logic signed [BW-1:0]     s1_bx;
    logic signed [BW-1:0]     s1_by;

    // Stage 1: capture A and the rotated B whenever the stage can accept.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_ax    <= '0;
            s1_ay    <= '0;
            s1_bx    <= '0;
            s1_by    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_ax    <= x1;
            s1_ay    <= y1;
            s1_bx    <= bt_x;
            s1_by    <= bt_y;
        end
    end

    // Butterfly sums at full width, so the halving step never overflows.
    logic signed [SW-1:0] ax_e;
    logic signed [SW-1:0] ay_e;
    logic signed [SW-1:0] bx_e;
    logic signed [SW-1:0] by_e;
    logic signed [SW-1:0] sum_x;
    logic signed [SW-1:0] sum_y;
    logic signed [SW-1:0] dif_x;
    logic signed [SW-1:0] dif_y;

    assign ax_e  = {{2{s1_ax[DATA_W-1]}}, s1_ax};
    assign ay_e  = {{2{s1_ay[DATA_W-1]}}, s1_ay};
    assign bx_e  = {s1_bx[BW-1], s1_bx};
    assign by_e  = {s1_by[BW-1], s1_by};
    assign sum_x = ax_e + bx_e;
    assign sum_y = ay_e + by_e;
    assign dif_x = ax_e - bx_e;
    assign dif_y = ay_e - by_e;

    // Halve one butterfly sum back to DATA_W bits.
    function automatic logic signed [DATA_W-1:0] halve(input logic signed [SW-1:0] v);
`ifdef IBFLY_ROUND_EN
        logic signed [SW-1:0] r;
        r = (v + ONE) >>> 1;
        if (r > MAX_V) begin
            return DATA_W'(MAX_V);
        end else if (r < MIN_V) begin
            return DATA_W'(MIN_V);
        end else begin
            return DATA_W'(r);
        end
`else
        return DATA_W'(v >>> 1);
`endif
    endfunction

    // Stage 2: halved butterfly results; this register drives the outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            xout1    <= '0;
            yout1    <= '0;
            xout2    <= '0;
            yout2    <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            xout1    <= halve(sum_x);
            yout1    <= halve(sum_y);
            xout2    <= halve(dif_x);
            yout2    <= halve(dif_y);
        end
    end

    // Delivered-pair counter, wraps naturally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pair_count <= '0;
        end else if (out_valid && out_ready) begin
            pair_count <= pair_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Bench for ifft_butterfly_pipe: directed vectors, backpressure, mid-flight
// reset and randomized streaming against an arithmetic reference model.
module tb_ifft_butterfly_pipe;

    localparam int DW = 16;
    localparam int CW = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic twiddle_j = 1'b0;
    logic out_ready = 1'b1;
    logic signed [DW-1:0] x1 = '0;
    logic signed [DW-1:0] y1 = '0;
    logic signed [DW-1:0] x2 = '0;
    logic signed [DW-1:0] y2 = '0;
    logic in_ready;
    logic out_valid;
    logic signed [DW-1:0] xout1;
    logic signed [DW-1:0] yout1;
    logic signed [DW-1:0] xout2;
    logic signed [DW-1:0] yout2;
    logic [CW-1:0] pair_count;

    ifft_butterfly_pipe #(.DATA_W(DW), .COUNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .twiddle_j(twiddle_j),
        .out_valid(out_valid), .out_ready(out_ready),
        .xout1(xout1), .yout1(yout1), .xout2(xout2), .yout2(yout2),
        .pair_count(pair_count)
    );

    // clock
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [CW-1:0] exp_count = '0;
    logic rand_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Halve with floor (or round-half-up and clamp in the rounding build).
    function automatic logic [DW-1:0] ref_half(input int v);
        int q;
`ifdef IBFLY_ROUND_EN
        v = v + 1;
`endif
        q = (v - (((v % 2) + 2) % 2)) / 2;
`ifdef IBFLY_ROUND_EN
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`endif
        return DW'(q);
    endfunction

    // (A + B*W)/2 and (A - B*W)/2 with W = 1 or +j, packed {x1,y1,x2,y2}.
    function automatic logic [63:0] ref_model(input int ax, input int ay, input int bx, input int by,
                                              input logic tw);
        int wx;
        int wy;
        wx = tw ? -by : bx;
        wy = tw ? bx : by;
        return {ref_half(ax + wx), ref_half(ay + wy), ref_half(ax - wx), ref_half(ay - wy)};
    endfunction

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(a), DW'(b), DW'(c), DW'(d)};
    endfunction

    function automatic logic signed [DW-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return -16'sd32768;
            1: return 16'sd32767;
            default: return DW'($urandom);
        endcase
    endfunction

    // Scoreboard: transfers are sampled mid-cycle, ahead of the edge that commits them.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_count = '0;
        end else begin
            check_eq("pair_count", 64'(pair_count), 64'(exp_count));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 64'(exp_q.size()), 64'(1));
                end else begin
                    check_eq("sb_data", {xout1, yout1, xout2, yout2}, exp_q.pop_front());
                end
                exp_count = exp_count + 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(x1, y1, x2, y2, twiddle_j));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one pair and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input logic signed [DW-1:0] c, input logic signed [DW-1:0] d,
                        input logic tw);
        x1 = a;
        y1 = b;
        x2 = c;
        y2 = d;
        twiddle_j = tw;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                return;
            end
            @(posedge clock);
            #1;
        end
        check_eq("send_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic send_rand();
        send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
    endtask

    // One pair into an empty pipe: stage 1 only after the accepting edge, output after the next.
    task automatic directed(input string tag, input logic signed [DW-1:0] a,
                            input logic signed [DW-1:0] b, input logic signed [DW-1:0] c,
                            input logic signed [DW-1:0] d, input logic tw, input logic [63:0] exp);
        out_ready = 1'b1;
        in_valid = 1'b0;
        idle(4);
        send(a, b, c, d, tw);
        in_valid = 1'b0;
        check_eq({tag, "_early"}, 64'(out_valid), 64'(0));
        idle(1);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
        check_eq(tag, {xout1, yout1, xout2, yout2}, exp);
    endtask

    initial begin
        int acc;
        logic took;
        logic [CW-1:0] base;

        // reset state
        idle(3);
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("rst_count", 64'(pair_count), 64'(0));
        check_eq("rst_data", {xout1, yout1, xout2, yout2}, 64'(0));
        reset_n = 1'b1;
        idle(2);

        // directed vectors
        directed("rotate", 100, 0, 0, 50, 1'b1, pack4(25, 0, 75, 0));
        directed("w0", 40, -20, 10, 6, 1'b0, pack4(25, -7, 15, -13));
`ifdef IBFLY_ROUND_EN
        directed("round", -3, 3, 0, 0, 1'b0, pack4(-1, 2, -1, 2));
        directed("extreme", 32767, 0, 0, -32768, 1'b1, pack4(32767, 0, 0, 0));
`else
        directed("round", -3, 3, 0, 0, 1'b0, pack4(-2, 1, -2, 1));
        directed("extreme", 32767, 0, 0, -32768, 1'b1, pack4(32767, 0, -1, 0));
`endif

        // backpressure: 8 pairs, consumer stalled for 5 cycles
        idle(4);
        base = exp_count;
        out_ready = 1'b0;
        acc = 0;
        x1 = rnd_val(); y1 = rnd_val(); x2 = rnd_val(); y2 = rnd_val();
        twiddle_j = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            took = in_ready;
            @(posedge clock);
            #1;
            if (took) begin
                acc++;
                x1 = rnd_val(); y1 = rnd_val(); x2 = rnd_val(); y2 = rnd_val();
                twiddle_j = 1'($urandom_range(0, 1));
            end
        end
        check_eq("bp_accepts", 64'(acc), 64'(2));
        check_eq("bp_in_ready", 64'(in_ready), 64'(0));
        check_eq("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        for (int i = acc; i < 8; i++) send_rand();
        in_valid = 1'b0;
        idle(5);
        check_eq("bp_count", 64'(pair_count), 64'(base + 16'd8));
        check_eq("bp_drained", 64'(exp_q.size()), 64'(0));

        // reset with two pairs in flight
        out_ready = 1'b0;
        send_rand();
        send_rand();
        in_valid = 1'b0;
        check_eq("full_in_ready", 64'(in_ready), 64'(0));
        reset_n = 1'b0;
        idle(1);
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_count", 64'(pair_count), 64'(0));
        check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
        reset_n = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // randomized streaming with random consumer stalls
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        idle($urandom_range(1, 3));
                    end
                    send_rand();
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        check_eq("rand_drained", 64'(exp_q.size()), 64'(0));
        check_eq("rand_idle_in_ready", 64'(in_ready), 64'(1));
        check_eq("rand_idle_out_valid", 64'(out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
